// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous-FIFO write port
// among NUM_REQ producers, with burst ownership of up to MAX_BURST beats.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   i_req              per-requester valid, held with data until granted
//   i_data             requester data, slice k = [k*DATA_W +: DATA_W]
//   o_gnt              one-hot accept strobe (combinational, zero latency)
//   i_fifo_full        FIFO full: no beat is accepted
//   i_fifo_alm_full    FIFO almost-full: every accepted beat ends the turn
//   o_fifo_wren        FIFO write enable (combinational)
//   o_fifo_wrdata      FIFO write data (combinational)
//   o_busy             burst ownership active
//   o_owner            current or last owner index
//
// Optional (macro FIFO_WR_ARB_STATS_EN):
//   o_stat_cnt         16-bit wrapping grant counter per requester
//   o_stall_cnt        16-bit wrapping count of cycles a request is blocked by full
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*DATA_W-1:0]   i_data,
  output logic [NUM_REQ-1:0]          o_gnt,
  input  logic                        i_fifo_full,
  input  logic                        i_fifo_alm_full,
  output logic                        o_fifo_wren,
  output logic [DATA_W-1:0]           o_fifo_wrdata,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       o_stat_cnt,
  output logic [15:0]                 o_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [PTR_W-1:0]   sel;
  logic               found;
  logic               accept;
  logic               burst_end;

  // Index arithmetic modulo NUM_REQ (handles non-power-of-2 counts).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Candidate selection, accept decision and next state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    sel        = rr_ptr_q;
    found      = 1'b0;

    if (state_q == S_BURST) begin
      // Only the owner is eligible during a burst.
      sel   = owner_q;
      found = i_req[owner_q];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && i_req[wrap_add(rr_ptr_q, i)]) begin
          sel   = wrap_add(rr_ptr_q, i);
          found = 1'b1;
        end
      end
    end

    accept    = found && !i_fifo_full;
    burst_end = ((beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) || i_fifo_alm_full;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = sel;
          if (burst_end) begin
            rr_ptr_d = wrap_add(sel, 1);
          end else begin
            state_d    = S_BURST;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      S_BURST: begin
        if (!i_req[owner_q]) begin
          // Owner dropped: release with a one-cycle bubble.
          state_d    = S_IDLE;
          rr_ptr_d   = wrap_add(owner_q, 1);
          beat_cnt_d = '0;
        end else if (accept) begin
          if (burst_end) begin
            state_d    = S_IDLE;
            rr_ptr_d   = wrap_add(owner_q, 1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port outputs are combinational; gating with rstn kills any beat
  // the moment reset asserts.
  always_comb begin
    o_gnt         = '0;
    o_fifo_wren   = 1'b0;
    o_fifo_wrdata = '0;
    if (rstn) begin
      o_fifo_wrdata = i_data[32'(sel)*DATA_W +: DATA_W];
      if (accept) begin
        o_gnt       = NUM_REQ'(1) << sel;
        o_fifo_wren = 1'b1;
      end
    end
  end

  assign o_busy  = (state_q == S_BURST);
  assign o_owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_q, stat_d;
  logic [15:0]              stall_q, stall_d;

  // Per-requester grant counts and full-stall count, all wrapping.
  always_comb begin
    stat_d  = stat_q;
    stall_d = stall_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (o_gnt[k]) stat_d[k] = stat_q[k] + 16'd1;
    end
    if (found && i_fifo_full) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_q  <= '0;
      stall_q <= '0;
    end else begin
      stat_q  <= stat_d;
      stall_q <= stall_d;
    end
  end

  assign o_stat_cnt  = stat_q;
  assign o_stall_cnt = stall_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_W=128).
// Drivers push per-cycle expectations to a scoreboard queue; a negedge monitor
// pops and compares them against the combinational write-port outputs.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned NR = 4;

  logic            clk;
  logic            rstn;
  logic [NR-1:0]   i_req;
  logic [NR*DW-1:0] i_data;
  logic [NR-1:0]   o_gnt;
  logic            i_fifo_full;
  logic            i_fifo_alm_full;
  logic            o_fifo_wren;
  logic [DW-1:0]   o_fifo_wrdata;
  logic            o_busy;
  logic [1:0]      o_owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] o_stat_cnt;
  logic [15:0]      o_stall_cnt;
`endif

  fifo_wr_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_req           (i_req),
    .i_data          (i_data),
    .o_gnt           (o_gnt),
    .i_fifo_full     (i_fifo_full),
    .i_fifo_alm_full (i_fifo_alm_full),
    .o_fifo_wren     (o_fifo_wren),
    .o_fifo_wrdata   (o_fifo_wrdata),
    .o_busy          (o_busy),
    .o_owner         (o_owner)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .o_stat_cnt      (o_stat_cnt),
    .o_stall_cnt     (o_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            g;      // granted requester, -1 for no grant
    logic          busy;
    int            owner;  // -1 to skip
    logic [DW-1:0] data;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] rand_data();
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR*DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Record the expectation for the cycle whose inputs were just applied.
  task automatic push_exp(input int g, input logic busy, input int owner, input string tag);
    exp_t e;
    e.g     = g;
    e.busy  = busy;
    e.owner = owner;
    e.data  = (g >= 0) ? i_data[g*DW +: DW] : '0;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic full, input logic alm,
                       input int g, input logic busy, input int owner, input string tag);
    @(posedge clk);
    #1;
    i_req           = req;
    i_fifo_full     = full;
    i_fifo_alm_full = alm;
    i_data          = rand_data();
    push_exp(g, busy, owner, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"},    DW'(o_gnt),         '0);
    check_eq({tag, "_wren"},   DW'(o_fifo_wren),   '0);
    check_eq({tag, "_busy"},   DW'(o_busy),        '0);
    check_eq({tag, "_owner"},  DW'(o_owner),       '0);
    check_eq({tag, "_wrdata"}, o_fifo_wrdata,      '0);
`ifdef FIFO_WR_ARB_STATS_EN
    check_eq({tag, "_stat"},   DW'(o_stat_cnt),    '0);
    check_eq({tag, "_stall"},  DW'(o_stall_cnt),   '0);
`endif
  endtask

  // Reset with all requests raised, outputs checked while rstn is low.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn            = 1'b0;
    i_req           = '1;
    i_fifo_full     = 1'b0;
    i_fifo_alm_full = 1'b0;
    i_data          = rand_data();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    i_req = '0;
    rstn  = 1'b1;
  endtask

  // Scoreboard monitor: one expectation per driven cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [NR-1:0] one;
      logic [NR-1:0] eg;
      e   = sb.pop_front();
      one = 4'b0001;
      eg  = (e.g >= 0) ? (one << e.g) : '0;
      check_eq({e.tag, "_gnt"},  DW'(o_gnt),       DW'(eg));
      check_eq({e.tag, "_wren"}, DW'(o_fifo_wren), DW'(e.g >= 0));
      if (e.g >= 0) check_eq({e.tag, "_wrdata"}, o_fifo_wrdata, e.data);
      check_eq({e.tag, "_busy"}, DW'(o_busy), DW'(e.busy));
      if (e.owner >= 0) check_eq({e.tag, "_owner"}, DW'(o_owner), DW'(e.owner));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn            = 1'b0;
    i_req           = '0;
    i_data          = '0;
    i_fifo_full     = 1'b0;
    i_fifo_alm_full = 1'b0;
    do_reset();

    // 1: all requesting, four-beat bursts in round-robin order.
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++)
        drive(4'hF, 1'b0, 1'b0, r, (b != 0), (b != 0) ? r : -1, "t1");
    drive(4'hF, 1'b0, 1'b0, 0, 1'b0, -1, "t1_wrap");
`ifdef FIFO_WR_ARB_STATS_EN
    @(posedge clk);
    #1;
    check_eq("t1_stat0", DW'(o_stat_cnt[0  +: 16]), DW'(16'd5));
    check_eq("t1_stat1", DW'(o_stat_cnt[16 +: 16]), DW'(16'd4));
    check_eq("t1_stat3", DW'(o_stat_cnt[48 +: 16]), DW'(16'd4));
`endif

    // 2: lone requester 2, ten beats back-to-back across burst boundaries.
    do_reset();
    for (int b = 0; b < 10; b++)
      drive(4'b0100, 1'b0, 1'b0, 2, ((b % 4) != 0), ((b % 4) != 0) ? 2 : -1, "t2");

    // 3: full stalls req0's burst after beat 2, then handover to req1.
    do_reset();
    drive(4'b0011, 1'b0, 1'b0, 0,  1'b0, -1, "t3_b1");
    drive(4'b0011, 1'b0, 1'b0, 0,  1'b1, 0,  "t3_b2");
    for (int s = 0; s < 3; s++)
      drive(4'b0011, 1'b1, 1'b0, -1, 1'b1, 0, "t3_stall");
    drive(4'b0011, 1'b0, 1'b0, 0,  1'b1, 0,  "t3_b3");
    drive(4'b0011, 1'b0, 1'b0, 0,  1'b1, 0,  "t3_b4");
    drive(4'b0011, 1'b0, 1'b0, 1,  1'b0, -1, "t3_hand");
`ifdef FIFO_WR_ARB_STATS_EN
    @(posedge clk);
    #1;
    check_eq("t3_stall_cnt", DW'(o_stall_cnt), DW'(16'd3));
`endif

    // 4: almost-full forces single-beat turns.
    do_reset();
    for (int b = 0; b < 6; b++)
      drive(4'b0011, 1'b0, 1'b1, b % 2, 1'b0, -1, "t4");

    // 5: owner req1 drops after beat 2 -> bubble, then req2.
    do_reset();
    drive(4'b0110, 1'b0, 1'b0, 1,  1'b0, -1, "t5_b1");
    drive(4'b0110, 1'b0, 1'b0, 1,  1'b1, 1,  "t5_b2");
    drive(4'b0100, 1'b0, 1'b0, -1, 1'b1, 1,  "t5_bubble");
    drive(4'b0100, 1'b0, 1'b0, 2,  1'b0, -1, "t5_next");

    // 6: reset during beat 3 of a burst kills the beat asynchronously.
    do_reset();
    drive(4'hF, 1'b0, 1'b0, 0, 1'b0, -1, "t6_b1");
    drive(4'hF, 1'b0, 1'b0, 0, 1'b1, 0,  "t6_b2");
    @(posedge clk);
    #1;
    i_data = rand_data();
    #1;
    check_eq("t6_pre_gnt",  DW'(o_gnt),       DW'(4'b0001));
    check_eq("t6_pre_wren", DW'(o_fifo_wren), DW'(1'b1));
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    i_data = rand_data();
    push_exp(0, 1'b0, -1, "t6_first");

    @(negedge clk);
    #1;
    check_eq("sb_empty", DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
